// File: rtl/rvfi_fetch_pkg.sv
// Shared types and helpers for the formal-harness instruction-fetch responder.
// One FIFO entry holds a fully composed response plus its remaining latency.
package rvfi_fetch_pkg;

  localparam int HW_BYTES = 2;
  localparam int ADDR_MAX = 64;

  typedef struct packed {
    logic [15:0] hw0;
    logic [15:0] hw1;
    logic        err;
    logic [3:0]  age;
  } fetch_entry_t;

  // True when halfword k of the word at base lands on imem_addr; addr_mask
  // truncates the sum to the harness XLEN so the top of memory wraps to zero.
  function automatic logic hw_match(input logic [ADDR_MAX-1:0] base,
                                    input logic                k,
                                    input logic [ADDR_MAX-1:0] imem_addr,
                                    input logic [ADDR_MAX-1:0] addr_mask);
    logic [ADDR_MAX-1:0] hw_addr;
    hw_addr = (base + (k ? ADDR_MAX'(HW_BYTES) : '0)) & addr_mask;
    return hw_addr == (imem_addr & addr_mask);
  endfunction

endpackage

// File: rtl/rvfi_imem_fetch_responder_if.sv
// Fetch request/response handshake between the core wrapper (master) and the
// instruction-memory responder (slave).
interface rvfi_imem_fetch_responder_if #(
  parameter int XLEN = 32
) ();

  logic            fetch_req_valid;
  logic            fetch_req_ready;
  logic [XLEN-1:0] fetch_req_addr;
  logic            fetch_rsp_valid;
  logic            fetch_rsp_ready;
  logic [31:0]     fetch_rsp_data;
  logic            fetch_rsp_error;

  modport master (
    output fetch_req_valid, fetch_req_addr, fetch_rsp_ready,
    input  fetch_req_ready, fetch_rsp_valid, fetch_rsp_data, fetch_rsp_error
  );

  modport slave (
    input  fetch_req_valid, fetch_req_addr, fetch_rsp_ready,
    output fetch_req_ready, fetch_rsp_valid, fetch_rsp_data, fetch_rsp_error
  );

endinterface

// File: rtl/rvfi_imem_fetch_fifo.sv
// Circular buffer of composed fetch responses. Every entry's age counts down
// each cycle regardless of position, so a queued entry may become ready early.
module rvfi_imem_fetch_fifo
  import rvfi_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  fetch_entry_t             entry_in,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage is never reset: a cleared count makes stale slots invisible.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (wr_ptr == PTR_W'(i))) begin
        mem[i] <= entry_in;
      end else if (mem[i].age != 4'd0) begin
        mem[i].age <= mem[i].age - 4'd1;
      end
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/rvfi_imem_fetch_responder.sv
// Instruction-fetch responder for the formal top: returns imem_data for the
// constrained halfword and free_data elsewhere, in order, with bounded latency.
module rvfi_imem_fetch_responder
  import rvfi_fetch_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [XLEN-1:0]          imem_addr,
  input  logic [15:0]              imem_data,
  input  logic [31:0]              free_data,
  output logic [$clog2(DEPTH):0]   outstanding,
  rvfi_imem_fetch_responder_if.slave fetch
);

  localparam int                  CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [ADDR_MAX-1:0] ADDR_MASK = ADDR_MAX'({XLEN{1'b1}});

  logic [XLEN-1:0] base;
  fetch_entry_t    entry_in;
  fetch_entry_t    head;
  logic            push;
  logic            pop;
  logic            empty;
  logic [CNT_W-1:0] count;

  // Request side: the response is composed at accept time so later free_data
  // changes cannot disturb it.
  always_comb begin
    base         = {fetch.fetch_req_addr[XLEN-1:1], 1'b0};
    entry_in     = '0;
    entry_in.err = fetch.fetch_req_addr[0];
    entry_in.age = 4'(LATENCY);
    if (!entry_in.err) begin
      entry_in.hw0 = hw_match(ADDR_MAX'(base), 1'b0, ADDR_MAX'(imem_addr), ADDR_MASK)
                     ? imem_data : free_data[15:0];
      entry_in.hw1 = hw_match(ADDR_MAX'(base), 1'b1, ADDR_MAX'(imem_addr), ADDR_MASK)
                     ? imem_data : free_data[31:16];
    end
  end

  // Full means not ready, even when the head pops this same cycle.
  assign fetch.fetch_req_ready = enable && !reset && (count < CNT_W'(DEPTH));
  assign push                  = fetch.fetch_req_valid && fetch.fetch_req_ready;

  rvfi_imem_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .entry_in (entry_in),
    .pop      (pop),
    .head     (head),
    .empty    (empty),
    .count    (count)
  );

  // Response side: data and error are forced to zero whenever nothing is offered.
  assign fetch.fetch_rsp_valid = !empty && (head.age == 4'd0);
  assign pop                   = fetch.fetch_rsp_valid && fetch.fetch_rsp_ready;
  assign fetch.fetch_rsp_data  = fetch.fetch_rsp_valid ? {head.hw1, head.hw0} : 32'd0;
  assign fetch.fetch_rsp_error = fetch.fetch_rsp_valid && head.err;
  assign outstanding           = count;

`ifdef RISCV_FORMAL
  logic        stall_p1;
  logic [31:0] data_p1;
  logic        err_p1;

  always_ff @(posedge clock) begin
    stall_p1 <= !reset && fetch.fetch_rsp_valid && !fetch.fetch_rsp_ready;
    data_p1  <= fetch.fetch_rsp_data;
    err_p1   <= fetch.fetch_rsp_error;
  end

  always_comb begin
    if (!reset) begin
      assert (count <= CNT_W'(DEPTH));
      assert (!(pop && empty));
      if (stall_p1) begin
        assert (fetch.fetch_rsp_valid);
        assert (fetch.fetch_rsp_data == data_p1);
        assert (fetch.fetch_rsp_error == err_p1);
      end
      if (push && !entry_in.err) begin
        if (hw_match(ADDR_MAX'(base), 1'b0, ADDR_MAX'(imem_addr), ADDR_MASK))
          assert (entry_in.hw0 == imem_data);
        if (hw_match(ADDR_MAX'(base), 1'b1, ADDR_MAX'(imem_addr), ADDR_MASK))
          assert (entry_in.hw1 == imem_data);
      end
    end
  end
`endif

endmodule

// File: tb/tb_rvfi_imem_fetch_responder.sv
// Directed and randomized bench for rvfi_imem_fetch_responder against a
// transaction-level queue model of the fetch responder.
module tb_rvfi_imem_fetch_responder;

  localparam int XLEN    = 32;
  localparam int DEPTH   = 4;
  localparam int LATENCY = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] imem_addr;
  logic [15:0] imem_data;
  logic [31:0] free_data;
  logic [2:0]  outstanding;

  rvfi_imem_fetch_responder_if #(.XLEN(XLEN)) fetch_if ();

  rvfi_imem_fetch_responder #(
    .XLEN    (XLEN),
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .free_data   (free_data),
    .outstanding (outstanding),
    .fetch       (fetch_if)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          rdy;
  } exp_t;

  exp_t q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Expected response for a fetch at addr, straight from the address rules.
  function automatic exp_t expect_of(input logic [31:0] addr, input logic [31:0] fd);
    exp_t        e;
    logic [31:0] a;
    e.err  = addr[0];
    e.data = 32'd0;
    e.rdy  = 0;
    if (!e.err) begin
      for (int k = 0; k < 2; k++) begin
        a = (addr & ~32'd1) + 32'(2 * k);
        e.data[16*k +: 16] = (a == imem_addr) ? imem_data : fd[16*k +: 16];
      end
    end
    return e;
  endfunction

  task automatic step();
    logic exp_ready;
    logic exp_valid;
    logic acc;
    logic pop;
    exp_t e;
    free_data = $urandom();
    #2;
    exp_ready = enable && !reset && (q.size() < DEPTH);
    exp_valid = !reset && (q.size() > 0) && (cyc >= q[0].rdy);
    chk("req_ready", 32'(fetch_if.fetch_req_ready), 32'(exp_ready));
    if (!reset) begin
      chk("outstanding", 32'(outstanding), 32'(q.size()));
      chk("rsp_valid", 32'(fetch_if.fetch_rsp_valid), 32'(exp_valid));
      if (exp_valid) begin
        chk("rsp_data", fetch_if.fetch_rsp_data, q[0].data);
        chk("rsp_error", 32'(fetch_if.fetch_rsp_error), 32'(q[0].err));
      end
    end
    acc   = fetch_if.fetch_req_valid && exp_ready;
    pop   = exp_valid && fetch_if.fetch_rsp_ready;
    e     = expect_of(fetch_if.fetch_req_addr, free_data);
    e.rdy = cyc + 1 + LATENCY;
    @(posedge clock);
    if (reset) begin
      q.delete();
    end else begin
      if (pop) q.delete(0);
      if (acc) q.push_back(e);
    end
    cyc++;
    #1;
  endtask

  task automatic req(input logic [31:0] a);
    fetch_if.fetch_req_valid = 1'b1;
    fetch_if.fetch_req_addr  = a;
    step();
    fetch_if.fetch_req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  initial begin
    logic [31:0] ra;
    reset                    = 1'b1;
    enable                   = 1'b1;
    imem_addr                = 32'h0000_0100;
    imem_data                = 16'hBEEF;
    free_data                = 32'd0;
    fetch_if.fetch_req_valid = 1'b0;
    fetch_if.fetch_req_addr  = 32'd0;
    fetch_if.fetch_rsp_ready = 1'b0;
    idle(2);
    reset = 1'b0;
    chk("reset_outstanding", 32'(outstanding), 32'd0);
    chk("reset_rsp_valid", 32'(fetch_if.fetch_rsp_valid), 32'd0);
    chk("reset_rsp_data", fetch_if.fetch_rsp_data, 32'd0);
    chk("reset_rsp_error", 32'(fetch_if.fetch_rsp_error), 32'd0);

    // Single fetch at the constrained address.
    fetch_if.fetch_rsp_ready = 1'b1;
    idle(2);
    req(32'h0000_0100);
    idle(5);

    // Straddle into the upper halfword, then a misaligned request.
    req(32'h0000_00FE);
    req(32'h0000_00FF);
    idle(6);

    // Fill under backpressure, hold, then drain.
    fetch_if.fetch_rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) req(32'h0000_00F8 + 32'(4 * i));
    chk("full_ready", 32'(fetch_if.fetch_req_ready), 32'd0);
    chk("full_outstanding", 32'(outstanding), 32'd4);
    idle(10);
    fetch_if.fetch_rsp_ready = 1'b1;
    idle(6);

    // Push and pop in the same cycle at two outstanding.
    fetch_if.fetch_rsp_ready = 1'b0;
    req(32'h0000_0100);
    req(32'h0000_0104);
    idle(3);
    fetch_if.fetch_rsp_ready = 1'b1;
    req(32'h0000_0102);
    chk("pushpop_outstanding", 32'(outstanding), 32'd2);
    idle(6);

    // Address wrap at the top of the 32-bit space.
    imem_addr = 32'h0000_0000;
    req(32'hFFFF_FFFE);
    idle(4);
    imem_addr = 32'h0000_0100;

    // Reset with three pending entries.
    fetch_if.fetch_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) req(32'h0000_0100 + 32'(2 * i));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midreset_outstanding", 32'(outstanding), 32'd0);
    chk("midreset_rsp_valid", 32'(fetch_if.fetch_rsp_valid), 32'd0);
    fetch_if.fetch_rsp_ready = 1'b1;
    idle(6);

    // enable low blocks accepts while pending entries drain.
    fetch_if.fetch_rsp_ready = 1'b0;
    req(32'h0000_0100);
    req(32'h0000_00FE);
    enable                   = 1'b0;
    fetch_if.fetch_req_valid = 1'b1;
    fetch_if.fetch_req_addr  = 32'h0000_0100;
    fetch_if.fetch_rsp_ready = 1'b1;
    idle(6);
    fetch_if.fetch_req_valid = 1'b0;
    enable                   = 1'b1;

    // Randomized traffic around the constrained address.
    imem_addr = $urandom() & ~32'd1;
    imem_data = 16'($urandom());
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 4))
        0:       ra = imem_addr;
        1:       ra = imem_addr - 32'd2;
        2:       ra = imem_addr + 32'd1;
        3:       ra = imem_addr - 32'd1;
        default: ra = $urandom();
      endcase
      enable                   = ($urandom_range(0, 9) != 0);
      reset                    = ($urandom_range(0, 99) == 0);
      fetch_if.fetch_req_valid = $urandom_range(0, 1) == 1;
      fetch_if.fetch_req_addr  = ra;
      fetch_if.fetch_rsp_ready = $urandom_range(0, 2) != 0;
      step();
    end
    reset                    = 1'b0;
    enable                   = 1'b1;
    fetch_if.fetch_req_valid = 1'b0;
    fetch_if.fetch_rsp_ready = 1'b1;
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
